// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32I pipeline. It tracks the destination register of each
// stage after decode and drives stall, bubble, flush, freeze and registered forwarding selects.
module hazard_ctrl #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] id_ir,
  input  logic            id_valid,
  input  logic            ex_redirect,
  input  logic            mem_wait,
  output logic            stall_if,
  output logic            stall_id,
  output logic            bubble_ex,
  output logic            flush_if,
  output logic            flush_id,
  output logic            freeze,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  typedef struct packed {
    logic            wen;
    logic [RIDX-1:0] rd;
  } ent_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic [6:0]      opc;
  logic [RIDX-1:0] rd, rs1, rs2;
  logic            wr_rd, rd_rs1, rd_rs2, is_load;

  ent_t ex_ent, mem_ent, wb_ent;
  logic ex_load;
  logic load_use, squash;

  assign opc = id_ir[6:0];
  assign rd  = id_ir[11:7];
  assign rs1 = id_ir[19:15];
  assign rs2 = id_ir[24:20];

  always_comb begin
    wr_rd   = 1'b0;
    rd_rs1  = 1'b0;
    rd_rs2  = 1'b0;
    is_load = 1'b0;
    case (opc)
      7'b0110111, 7'b0010111, 7'b1101111: wr_rd = 1'b1;
      7'b1100111: begin wr_rd = 1'b1; rd_rs1 = 1'b1; end
      7'b0000011: begin wr_rd = 1'b1; rd_rs1 = 1'b1; is_load = 1'b1; end
      7'b0010011: begin wr_rd = 1'b1; rd_rs1 = 1'b1; end
      7'b0110011: begin wr_rd = 1'b1; rd_rs1 = 1'b1; rd_rs2 = 1'b1; end
      7'b1100011, 7'b0100011: begin rd_rs1 = 1'b1; rd_rs2 = 1'b1; end
      default: ;
    endcase
  end

  // x0 is never a producer, so a record with rd=0 cannot match.
  function automatic logic hit(ent_t e, logic [RIDX-1:0] r);
    return e.wen && (e.rd != '0) && (e.rd == r);
  endfunction

  function automatic logic [1:0] fsel(logic used, logic [RIDX-1:0] r, ent_t ex, ent_t mem);
    if (!used)          return FWD_RF;
    else if (hit(ex, r))  return FWD_EX;
    else if (hit(mem, r)) return FWD_MEM;
    else                return FWD_RF;
  endfunction

  assign load_use = id_valid && ex_load &&
                    ((rd_rs1 && hit(ex_ent, rs1)) || (rd_rs2 && hit(ex_ent, rs2)));

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        freeze = 1'b1;
      end else if (ex_redirect) begin
        flush_if  = 1'b1;
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  assign squash = bubble_ex || !id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ent  <= '0;
      mem_ent <= '0;
      wb_ent  <= '0;
      ex_load <= 1'b0;
      fwd_a   <= FWD_RF;
      fwd_b   <= FWD_RF;
    end else if (!mem_wait) begin
      wb_ent  <= mem_ent;
      mem_ent <= ex_ent;
      if (squash) begin
        ex_ent  <= '0;
        ex_load <= 1'b0;
        fwd_a   <= FWD_RF;
        fwd_b   <= FWD_RF;
      end else begin
        ex_ent  <= '{wen: wr_rd, rd: rd};
        ex_load <= is_load;
        fwd_a   <= fsel(rd_rs1, rs1, ex_ent, mem_ent);
        fwd_b   <= fsel(rd_rs2, rs2, ex_ent, mem_ent);
      end
    end
  end

  // The WB record is kept for visibility; the write-before-read register file never needs it.
  logic unused_bits;
  assign unused_bits = ^{id_ir[XLEN-1:25], id_ir[14:12], wb_ent};

endmodule
